// File: rtl/and_rr_scheduler.sv
// Round-robin scheduler that time-shares a single N-bit bitwise AND among R requesters.
// One operation at a time: grant/capture, execute, then hold the result until accepted.

module and_n_module #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);
  assign y = a & b;
endmodule

module and_rr_scheduler #(
  parameter  int N   = 4,
  parameter  int R   = 4,
  localparam int IDW = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] a_in,
  input  logic [R*N-1:0] b_in,
  output logic [R-1:0]   gnt,
  output logic [N-1:0]   res,
  output logic [IDW-1:0] res_id,
  output logic           res_valid,
  input  logic           res_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] ptr_nxt;
  logic [IDW-1:0] cur_id;
  logic [N-1:0]   op_a, op_b;
  logic [N-1:0]   and_y;
  logic           found;
  int             idx;

  and_n_module #(.N(N)) u_and (
    .a (op_a),
    .b (op_b),
    .y (and_y)
  );

  // Search order starts at ptr and wraps explicitly, so any R (not only powers of two) works.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < R; k++) begin
      idx = int'(ptr) + k;
      if (idx >= R) idx = idx - R;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  assign ptr_nxt = (winner == IDW'(R - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = EXEC;
      EXEC:    state_nxt = HOLD;
      HOLD:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      gnt       <= '0;
      res       <= '0;
      res_id    <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            ptr <= ptr_nxt;
            gnt <= {{(R-1){1'b0}}, 1'b1} << winner;
          end
        end
        EXEC: begin
          res       <= and_y;
          res_id    <= cur_id;
          res_valid <= 1'b1;
          gnt       <= '0;
        end
        HOLD: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: begin
          gnt       <= '0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: operand/ID capture registers are deliberately unreset; they are always written before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && found) begin
      cur_id <= winner;
      op_a   <= a_in[int'(winner)*N +: N];
      op_b   <= b_in[int'(winner)*N +: N];
    end
  end

endmodule

// File: tb/tb_and_rr_scheduler.sv
// Self-checking bench for and_rr_scheduler: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.

module tb_and_rr_scheduler;

  localparam int N   = 4;
  localparam int R   = 4;
  localparam int IDW = $clog2(R);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [R-1:0]   req;
  logic [R*N-1:0] a_in;
  logic [R*N-1:0] b_in;
  logic [R-1:0]   gnt;
  logic [N-1:0]   res;
  logic [IDW-1:0] res_id;
  logic           res_valid;
  logic           res_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  and_rr_scheduler #(.N(N), .R(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .res       (res),
    .res_id    (res_id),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding operation; a grant is visible for one cycle, then the
  // result is offered until accepted, and only then may the next round-robin winner be picked.
  logic [R-1:0]   m_gnt;
  logic [N-1:0]   m_res;
  int             m_res_id;
  logic           m_valid;
  int             m_turn;
  logic [N-1:0]   m_a, m_b;
  int             m_id;
  bit             m_started = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_started = 1;
      m_gnt     = '0;
      m_res     = '0;
      m_res_id  = 0;
      m_valid   = 1'b0;
      m_turn    = 0;
    end else if (m_started) begin
      if (m_gnt != '0) begin
        m_res    = m_a & m_b;
        m_res_id = m_id;
        m_valid  = 1'b1;
        m_gnt    = '0;
      end else if (m_valid) begin
        if (res_ready) m_valid = 1'b0;
      end else if (req != '0) begin
        for (int k = 0; k < R; k++) begin
          int cand;
          cand = (m_turn + k) % R;
          if (req[cand]) begin
            m_id   = cand;
            m_a    = a_in[cand*N +: N];
            m_b    = b_in[cand*N +: N];
            m_gnt  = '0;
            m_gnt[cand] = 1'b1;
            m_turn = (cand + 1) % R;
            break;
          end
        end
      end
    end
    #1;
    if (m_started) begin
      check("model_gnt", 32'(gnt), 32'(m_gnt));
      check("model_valid", 32'(res_valid), 32'(m_valid));
      check("model_res", 32'(res), 32'(m_res));
      check("model_res_id", 32'(res_id), 32'(m_res_id));
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    end
  end

  // Advance one clock; stimulus changes and literal checks happen 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_lane(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    a_in[i*N +: N] = a;
    b_in[i*N +: N] = b;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int c = 0; c < cycles; c++) step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 4'b1111;
    a_in      = 16'h0000;
    b_in      = 16'h0000;
    res_ready = 1'b1;

    // Reset held with all requests high: everything stays idle.
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_valid", 32'(res_valid), 32'd0);
      check("rst_res", 32'(res), 32'd0);
      check("rst_res_id", 32'(res_id), 32'd0);
    end

    // Single request: 1100 & 1010 = 1000.
    rst_n = 1'b1;
    req   = 4'b0001;
    set_lane(0, 4'b1100, 4'b1010);
    step();
    check("t2_gnt", 32'(gnt), 32'b0001);
    req = 4'b0000;
    step();
    check("t2_res", 32'(res), 32'b1000);
    check("t2_res_id", 32'(res_id), 32'd0);
    check("t2_valid", 32'(res_valid), 32'd1);
    step();
    check("t2_idle_valid", 32'(res_valid), 32'd0);
    check("t2_res_kept", 32'(res), 32'b1000);

    // All requesting: grants rotate 0,1,2,3,0, one every 3 cycles.
    do_reset(1);
    set_lane(0, 4'b1111, 4'b0001);
    set_lane(1, 4'b1110, 4'b0110);
    set_lane(2, 4'b1010, 4'b1111);
    set_lane(3, 4'b0101, 4'b1101);
    req = 4'b1111;
    for (int c = 0; c < 13; c++) begin
      step();
      if (c % 3 == 0) check("t3_gnt_rot", 32'(gnt), 32'(4'b0001 << ((c / 3) % R)));
      else            check("t3_gnt_gap", 32'(gnt), 32'd0);
    end
    req = 4'b0000;
    for (int c = 0; c < 3; c++) step();

    // Sparse requests 1010: ids 1, 3, then wrap to 1.
    do_reset(1);
    req = 4'b1010;
    step(); check("t4_gnt_a", 32'(gnt), 32'b0010);
    step(); step();
    step(); check("t4_gnt_b", 32'(gnt), 32'b1000);
    step(); check("t4_res_id_b", 32'(res_id), 32'd3);
    step();
    step(); check("t4_gnt_c", 32'(gnt), 32'b0010);
    req = 4'b0000;
    for (int c = 0; c < 3; c++) step();

    // Backpressure: 0110 & 0011 = 0010 held for 5 stalled cycles while others request.
    do_reset(1);
    set_lane(0, 4'b0110, 4'b0011);
    res_ready = 1'b0;
    req       = 4'b0001;
    step(); check("t5_gnt", 32'(gnt), 32'b0001);
    req = 4'b1111;
    step(); check("t5_valid_up", 32'(res_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      step();
      check("t5_hold_valid", 32'(res_valid), 32'd1);
      check("t5_hold_res", 32'(res), 32'b0010);
      check("t5_hold_id", 32'(res_id), 32'd0);
      check("t5_hold_gnt", 32'(gnt), 32'd0);
    end
    res_ready = 1'b1;
    step();
    check("t5_release_valid", 32'(res_valid), 32'd0);
    check("t5_release_gnt", 32'(gnt), 32'd0);
    step(); check("t5_next_gnt", 32'(gnt), 32'b0010);
    req = 4'b0000;
    for (int c = 0; c < 3; c++) step();

    // Reset during EXEC discards the operation and returns the pointer to 0.
    do_reset(1);
    set_lane(2, 4'b1111, 4'b0101);
    set_lane(0, 4'b1001, 4'b1100);
    set_lane(3, 4'b0111, 4'b0111);
    req = 4'b0100;
    step(); check("t6_gnt", 32'(gnt), 32'b0100);
    rst_n = 1'b0;
    step();
    check("t6_abort_valid", 32'(res_valid), 32'd0);
    check("t6_abort_gnt", 32'(gnt), 32'd0);
    rst_n = 1'b1;
    req   = 4'b1001;
    step(); check("t6_ptr0_gnt", 32'(gnt), 32'b0001);
    step();
    check("t6_res", 32'(res), 32'b1000);
    check("t6_res_id", 32'(res_id), 32'd0);
    req = 4'b0000;
    for (int c = 0; c < 3; c++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
